fp_round_pipe: RTL

//   Parametrised, pipelined rounder for the two's-complement-to-float converter. Takes a normalised

---
 rtl/fp_round_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fp_round_pipe.sv
// Two-stage valid/ready rounder for the int-to-float converter. It rounds a normalised significand
// using the discarded low bits and a per-item mode, renormalises on carry, and saturates on overflow.
module fp_round_pipe #(
  parameter int unsigned EXP_W   = 3,
  parameter int unsigned FRAC_W  = 5,
  parameter int unsigned EXTRA_W = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   in_e,
  input  logic [FRAC_W-1:0]  in_f,
  input  logic [EXTRA_W-1:0] in_x,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   out_e,
  output logic [FRAC_W-1:0]  out_f,
  output logic               out_ovf,
  input  logic               sat_clr,
  output logic [CNT_W-1:0]   sat_count
);

  logic              r_s1_valid;
  logic [EXP_W-1:0]  r_s1_e;
  logic [FRAC_W-1:0] r_s1_f;
  logic              r_s1_inc;
  logic              r_s2_valid;
  logic [EXP_W-1:0]  r_s2_e;
  logic [FRAC_W-1:0] r_s2_f;
  logic              r_s2_ovf;
  logic [CNT_W-1:0]  r_sat_count;

  logic              w_s1_load;
  logic              w_s2_load;
  logic              w_round;
  logic              w_sticky;
  logic              w_lsb;
  logic              w_inc;
  logic [FRAC_W:0]   w_sum;
  logic [EXP_W-1:0]  w_e2;
  logic [FRAC_W-1:0] w_f2;
  logic              w_ovf2;
  logic              w_sat_inc;

  assign w_s2_load = ~r_s2_valid | out_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;

  assign w_round = in_x[EXTRA_W-1];
  assign w_lsb   = in_f[0];

  if (EXTRA_W > 1) begin : g_sticky
    assign w_sticky = |in_x[EXTRA_W-2:0];
  end else begin : g_no_sticky
    assign w_sticky = 1'b0;
  end

  always_comb begin
    w_inc = 1'b0;
    unique case (in_mode)
      2'd0: w_inc = w_round;
      2'd1: w_inc = 1'b0;
      2'd2: w_inc = w_round & (w_sticky | w_lsb);
      2'd3: w_inc = w_round | w_sticky;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, r_s1_f} + {{FRAC_W{1'b0}}, r_s1_inc};

  // A carry out means the sum is exactly 1000..0 with an extra leading bit, so shift and bump e.
  always_comb begin
    w_e2   = r_s1_e;
    w_f2   = w_sum[FRAC_W-1:0];
    w_ovf2 = 1'b0;
    if (w_sum[FRAC_W]) begin
      if (&r_s1_e) begin
        w_e2   = '1;
        w_f2   = '1;
        w_ovf2 = 1'b1;
      end else begin
        w_e2 = r_s1_e + EXP_W'(1);
        w_f2 = w_sum[FRAC_W:1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_e     <= '0;
      r_s1_f     <= '0;
      r_s1_inc   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_e   <= in_e;
        r_s1_f   <= in_f;
        r_s1_inc <= w_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_e     <= '0;
      r_s2_f     <= '0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_e   <= w_e2;
        r_s2_f   <= w_f2;
        r_s2_ovf <= w_ovf2;
      end
    end
  end

  assign w_sat_inc = r_s2_valid & out_ready & r_s2_ovf;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (w_sat_inc && !(&r_sat_count)) begin
      r_sat_count <= r_sat_count + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign out_e     = r_s2_e;
  assign out_f     = r_s2_f;
  assign out_ovf   = r_s2_ovf;
  assign sat_count = r_sat_count;

endmodule
